apb4_plic_claimer: RTL and testbench
====================================

// Module: apb4_plic_claimer
// PURPOSE
//  APB4 requester that services the PLIC from the hart side. On a PLIC interrupt it reads CLAIMCOMP, hands the
//  claimed ID to a handler over valid/ready, waits for handler done, then writes the same ID back to CLAIMCOMP.
//  Sits between the PLIC irq output and a local handler; its APB4 port drives the PLIC's APB4 slave port.
// PARAMETERS
//  BASE_ADDR     32'h0000_0000  PLIC base address on the APB4 bus
//  CLAIM_OFFSET  6'h24          CLAIMCOMP register byte offset (register index 9)
//  IRQ_WIDTH     5              claimed-ID width (IDs 1..31; 0 = none)
//  TIMEOUT_CYC   1024           handler-done timeout in cycles (only with PLIC_CLAIMER_TIMEOUT_EN)
// PORTS
//  pclk        in   1          APB4 clock
//  presetn     in   1          reset: asynchronous, active-low
//  en_i        in   1          service enable; 0 holds FSM in IDLE (a transfer in progress still completes)
//  irq_i       in   1          PLIC interrupt request (level)
//  paddr_o     out  32         APB4 address
//  pprot_o     out  3          APB4 protection, constant 3'b000
//  psel_o      out  1          APB4 select
//  penable_o   out  1          APB4 enable
//  pwrite_o    out  1          APB4 write
//  pwdata_o    out  32         APB4 write data
//  pstrb_o     out  4          APB4 strobes, 4'hF on writes, 4'h0 on reads
//  pready_i    in   1          APB4 ready
//  prdata_i    in   32         APB4 read data
//  pslverr_i   in   1          APB4 slave error
//  id_valid_o  out  1          claimed ID valid for handler
//  id_o        out  IRQ_WIDTH  claimed ID
//  id_ready_i  in   1          handler accepts ID
//  done_i      in   1          handler finished (single-cycle pulse)
//  busy_o      out  1          FSM not in IDLE
//  spur_o      out  1          1-cycle pulse: claim returned ID 0
//  err_o       out  1          1-cycle pulse: pslverr on any transfer, or timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; ID register 0. Async reset mid-transfer drops psel_o immediately.
//  States: IDLE, RD_SETUP, RD_ACCESS, DISPATCH, WAIT_DONE, WR_SETUP, WR_ACCESS.
//  IDLE -> RD_SETUP when en_i & irq_i (sampled at clock edge). Otherwise stays in IDLE.
//  RD_SETUP: psel=1, penable=0, pwrite=0, paddr=BASE_ADDR+CLAIM_OFFSET; 1 cycle -> RD_ACCESS.
//  RD_ACCESS: psel=1, penable=1; hold until pready_i. On pready_i: capture prdata_i[IRQ_WIDTH-1:0].
//   pslverr_i -> err_o pulse, go IDLE (no complete). ID==0 -> spur_o pulse, go IDLE. Else -> DISPATCH.
//  DISPATCH: id_valid_o=1, id_o stable; on id_ready_i -> WAIT_DONE. done_i is ignored before acceptance.
//  WAIT_DONE: on done_i -> WR_SETUP. done_i in the acceptance cycle is not counted.
//  WR_SETUP: psel=1, penable=0, pwrite=1, pwdata={zero-extended ID}, same paddr; 1 cycle -> WR_ACCESS.
//  WR_ACCESS: hold until pready_i; pslverr_i -> err_o pulse; always -> IDLE.
//  APB4 rules: paddr/pwrite/pwdata stable from SETUP through the pready cycle; psel_o drops in the cycle after
//   pready_i; at least 1 idle cycle between complete and next claim (IDLE state visited).
//  Min latency irq_i -> id_valid_o: 3 cycles with zero-wait slave. Min complete: 2 cycles after done_i.
//  irq_i dropping after IDLE exit does not abort; the claim read resolves it (ID 0 -> spurious).
//  en_i deassert outside IDLE: current service finishes, then FSM stays in IDLE.
//  spur_o and err_o never assert in the same cycle.
// CONFIGURATION
//  PLIC_CLAIMER_TIMEOUT_EN defined: counter starts on entry to WAIT_DONE; if TIMEOUT_CYC cycles pass with no
//   done_i, err_o pulses and FSM goes to WR_SETUP (forced complete). Counter clears on state exit.
//  Not defined: no counter; WAIT_DONE waits indefinitely; TIMEOUT_CYC unused.
// TESTING
//  T1 zero-wait slave returns 0x7, handler ready immediately, done after 5 cycles -> read at 0x24, id_o=7,
//     write 0x24 pwdata=0x0000_0007, busy_o falls, total 3+1+5+2 cycles.
//  T2 slave inserts 3 wait states on read and write -> address/control stable, psel_o held through pready.
//  T3 claim returns 0 -> spur_o one pulse, no id_valid_o, no write transfer, back to IDLE.
//  T4 pslverr_i on claim read -> err_o pulse, no dispatch; pslverr on complete -> err_o pulse, IDLE.
//  T5 presetn low during RD_ACCESS and during DISPATCH -> all outputs 0 asynchronously, resumes clean claim.
//  T6 (TIMEOUT_EN, TIMEOUT_CYC=16) no done_i -> err_o on cycle 16 of WAIT_DONE, write complete with held ID.

Source files
------------

// File: rtl/apb4_plic_claimer_if.sv
// APB4 requester bus between the PLIC claimer and the PLIC slave port.
// Signal suffixes are seen from the claimer (requester) side.
interface apb4_plic_claimer_if;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  modport master (
    output paddr_o,
    output pprot_o,
    output psel_o,
    output penable_o,
    output pwrite_o,
    output pwdata_o,
    output pstrb_o,
    input  pready_i,
    input  prdata_i,
    input  pslverr_i
  );

  modport slave (
    input  paddr_o,
    input  pprot_o,
    input  psel_o,
    input  penable_o,
    input  pwrite_o,
    input  pwdata_o,
    input  pstrb_o,
    output pready_i,
    output prdata_i,
    output pslverr_i
  );
endinterface

// File: rtl/apb4_plic_claimer.sv
// Hart-side PLIC claim/complete sequencer over APB4.
// Optional macro PLIC_CLAIMER_TIMEOUT_EN: handler-done timeout.
module apb4_plic_claimer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [5:0]  CLAIM_OFFSET = 6'h24,
  parameter int          IRQ_WIDTH    = 5,
  parameter int          TIMEOUT_CYC  = 1024
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 en_i,
  input  logic                 irq_i,
  apb4_plic_claimer_if.master  apb,
  output logic                 id_valid_o,
  output logic [IRQ_WIDTH-1:0] id_o,
  input  logic                 id_ready_i,
  input  logic                 done_i,
  output logic                 busy_o,
  output logic                 spur_o,
  output logic                 err_o
);

  localparam logic [31:0] CLAIM_ADDR =
    BASE_ADDR + {26'd0, CLAIM_OFFSET};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_DISPATCH,
    S_WAIT_DONE,
    S_WR_SETUP,
    S_WR_ACCESS
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [IRQ_WIDTH-1:0] id_q;
  logic [IRQ_WIDTH-1:0] id_d;
  logic                 to_hit;
  logic                 rd_ph;
  logic                 wr_ph;
  logic [IRQ_WIDTH-1:0] rd_id;

  assign rd_id = apb.prdata_i[IRQ_WIDTH-1:0];

`ifdef PLIC_CLAIMER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // count cycles spent in WAIT_DONE, cleared whenever the state is left
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT_DONE && state_d == S_WAIT_DONE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // timeout counter register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign to_hit = (state_q == S_WAIT_DONE) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_to;

  assign unused_to = ^32'(TIMEOUT_CYC);
  assign to_hit    = 1'b0;
`endif

  logic unused_rd;

  assign unused_rd = ^apb.prdata_i[31:IRQ_WIDTH];

  // state and claimed-ID registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // next state, ID capture and the spur/err pulses
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    spur_o  = 1'b0;
    err_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en_i && irq_i) begin
          state_d = S_RD_SETUP;
        end
      end
      S_RD_SETUP: begin
        state_d = S_RD_ACCESS;
      end
      S_RD_ACCESS: begin
        if (apb.pready_i) begin
          id_d = rd_id;
          if (apb.pslverr_i) begin
            err_o   = 1'b1;
            state_d = S_IDLE;
          end else if (rd_id == '0) begin
            spur_o  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (id_ready_i) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done_i) begin
          state_d = S_WR_SETUP;
        end else if (to_hit) begin
          err_o   = 1'b1;
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_ACCESS;
      end
      S_WR_ACCESS: begin
        if (apb.pready_i) begin
          err_o   = apb.pslverr_i;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_ph = (state_q == S_RD_SETUP) ||
                 (state_q == S_RD_ACCESS);
  assign wr_ph = (state_q == S_WR_SETUP) ||
                 (state_q == S_WR_ACCESS);

  assign apb.psel_o    = rd_ph || wr_ph;
  assign apb.penable_o = (state_q == S_RD_ACCESS) ||
                         (state_q == S_WR_ACCESS);
  assign apb.pwrite_o  = wr_ph;
  assign apb.paddr_o   = (rd_ph || wr_ph) ? CLAIM_ADDR : '0;
  assign apb.pwdata_o  = wr_ph ?
    {{(32-IRQ_WIDTH){1'b0}}, id_q} : '0;
  assign apb.pstrb_o   = wr_ph ? 4'hF : 4'h0;
  assign apb.pprot_o   = 3'b000;

  assign id_valid_o = (state_q == S_DISPATCH);
  assign id_o       = id_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_apb4_plic_claimer.sv
// Self-checking bench for apb4_plic_claimer.
// Define PLIC_CLAIMER_TIMEOUT_EN to exercise the timeout path.
module tb_apb4_plic_claimer;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       en_i;
  logic       irq_i;
  logic       id_valid_o;
  logic [4:0] id_o;
  logic       id_ready_i;
  logic       done_i;
  logic       busy_o;
  logic       spur_o;
  logic       err_o;

  int          cfg_wait;
  logic [31:0] cfg_rdata;
  logic        cfg_err_rd;
  logic        cfg_err_wr;

  int n_tests = 0;
  int n_fail  = 0;

  apb4_plic_claimer_if bus();

  apb4_plic_claimer #(
    .BASE_ADDR   (32'h0000_0000),
    .CLAIM_OFFSET(6'h24),
    .IRQ_WIDTH   (5),
    .TIMEOUT_CYC (16)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .en_i      (en_i),
    .irq_i     (irq_i),
    .apb       (bus),
    .id_valid_o(id_valid_o),
    .id_o      (id_o),
    .id_ready_i(id_ready_i),
    .done_i    (done_i),
    .busy_o    (busy_o),
    .spur_o    (spur_o),
    .err_o     (err_o)
  );

  always #5 pclk = ~pclk;

  // APB4 slave model with cfg_wait wait states
  int wcnt;
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) wcnt <= 0;
    else if (bus.psel_o && bus.penable_o && !bus.pready_i)
      wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign bus.pready_i = bus.psel_o && bus.penable_o &&
                        (wcnt >= cfg_wait);
  assign bus.prdata_i = (bus.pready_i && !bus.pwrite_o) ?
                        cfg_rdata : 32'h0;
  assign bus.pslverr_i = bus.pready_i &&
    (bus.pwrite_o ? cfg_err_wr : cfg_err_rd);

  // bus monitor: event counters and protocol rule violations
  int          spur_n = 0;
  int          err_n  = 0;
  int          rd_n   = 0;
  int          wr_n   = 0;
  int          viol_n = 0;
  logic [31:0] last_raddr = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        pv_psel = 1'b0;
  logic        pv_done = 1'b0;
  logic        pv_wr = 1'b0;
  logic [31:0] pv_addr = '0;
  logic [31:0] pv_wdata = '0;

  always @(negedge pclk) begin
    logic dn;
    dn = bus.psel_o && bus.penable_o && bus.pready_i;
    if (spur_o) spur_n = spur_n + 1;
    if (err_o) err_n = err_n + 1;
    if (dn && !bus.pwrite_o) begin
      rd_n = rd_n + 1;
      last_raddr = bus.paddr_o;
    end
    if (dn && bus.pwrite_o) begin
      wr_n = wr_n + 1;
      last_waddr = bus.paddr_o;
      last_wdata = bus.pwdata_o;
    end
    if (bus.psel_o && pv_psel && !pv_done &&
        (bus.paddr_o != pv_addr || bus.pwrite_o != pv_wr ||
         bus.pwdata_o != pv_wdata)) viol_n = viol_n + 1;
    if (pv_done && bus.psel_o) viol_n = viol_n + 1;
    if (spur_o && err_o) viol_n = viol_n + 1;
    if (!bus.psel_o && bus.penable_o) viol_n = viol_n + 1;
    if (bus.psel_o &&
        bus.pstrb_o != (bus.pwrite_o ? 4'hF : 4'h0))
      viol_n = viol_n + 1;
    if (bus.pprot_o != 3'b000) viol_n = viol_n + 1;
    pv_psel  = bus.psel_o;
    pv_done  = dn;
    pv_wr    = bus.pwrite_o;
    pv_addr  = bus.paddr_o;
    pv_wdata = bus.pwdata_o;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input bit drop);
    int k;
    for (k = 0; k < 40 && !id_valid_o; k++) begin
      tick();
      if (busy_o && drop) irq_i = 1'b0;
    end
    if (!id_valid_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: id_valid_o timeout got 0 expected 1", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 60 && busy_o; k++) tick();
    if (busy_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: busy_o timeout got 1 expected 0", nm);
    end
  endtask

  typedef struct {
    int          wt;
    logic [31:0] rdata;
    bit          erd;
    bit          ewr;
    int          rdy;
    int          dn;
    int          e_cyc;
    int          e_spur;
    int          e_err;
    int          e_wr;
    int          e_disp;
    logic [4:0]  e_id;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int vi, input vec_t v);
    int   k, rw, cd, cyc, disp;
    int   s0, e0, w0, r0, x0;
    bit   busy_seen, vprev, got, fin;
    logic [4:0] idv;
    cfg_wait   = v.wt;
    cfg_rdata  = v.rdata;
    cfg_err_rd = v.erd;
    cfg_err_wr = v.ewr;
    s0 = spur_n; e0 = err_n; w0 = wr_n;
    r0 = rd_n; x0 = viol_n;
    rw = v.rdy; cd = 0; cyc = 0; disp = 0;
    busy_seen = 0; vprev = 0; got = 0; fin = 0;
    idv = '0;
    en_i  = 1'b1;
    irq_i = 1'b1;
    for (k = 1; k <= 200 && !fin; k++) begin
      tick();
      done_i = 1'b0;
      if (busy_o) begin
        busy_seen = 1;
        irq_i = 1'b0;
      end
      if (id_ready_i && vprev) begin
        id_ready_i = 1'b0;
        disp++;
        if (v.dn <= 1) done_i = 1'b1;
        else cd = v.dn - 1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) done_i = 1'b1;
      end
      if (id_valid_o && !id_ready_i) begin
        if (!got) begin
          idv = id_o;
          got = 1;
        end else if (id_o != idv) begin
          chk($sformatf("v%0d id_o stable", vi), id_o, idv);
        end
        if (rw == 0) id_ready_i = 1'b1;
        else rw--;
      end
      vprev = id_valid_o;
      if (busy_seen && !busy_o) begin
        fin = 1;
        cyc = k;
      end
    end
    done_i = 1'b0;
    id_ready_i = 1'b0;
    chk($sformatf("v%0d finished", vi), 32'(fin), 32'd1);
    chk($sformatf("v%0d cycles", vi), cyc, v.e_cyc);
    chk($sformatf("v%0d spur", vi), spur_n - s0, v.e_spur);
    chk($sformatf("v%0d err", vi), err_n - e0, v.e_err);
    chk($sformatf("v%0d reads", vi), rd_n - r0, 1);
    chk($sformatf("v%0d writes", vi), wr_n - w0, v.e_wr);
    chk($sformatf("v%0d dispatch", vi), disp, v.e_disp);
    chk($sformatf("v%0d raddr", vi), last_raddr, 32'h24);
    chk($sformatf("v%0d protocol", vi), viol_n - x0, 0);
    if (v.e_disp != 0)
      chk($sformatf("v%0d id", vi), 32'(idv), 32'(v.e_id));
    if (v.e_wr != 0) begin
      chk($sformatf("v%0d waddr", vi), last_waddr, 32'h24);
      chk($sformatf("v%0d wdata", vi), last_wdata,
          {27'd0, v.e_id});
    end
    tick();
    tick();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " psel"}, 32'(bus.psel_o), 32'd0);
    chk({nm, " penable"}, 32'(bus.penable_o), 32'd0);
    chk({nm, " paddr"}, bus.paddr_o, 32'd0);
    chk({nm, " pwrite"}, 32'(bus.pwrite_o), 32'd0);
    chk({nm, " pwdata"}, bus.pwdata_o, 32'd0);
    chk({nm, " pstrb"}, 32'(bus.pstrb_o), 32'd0);
    chk({nm, " id_valid"}, 32'(id_valid_o), 32'd0);
    chk({nm, " id"}, 32'(id_o), 32'd0);
    chk({nm, " busy"}, 32'(busy_o), 32'd0);
    chk({nm, " spur_err"}, 32'({spur_o, err_o}), 32'd0);
  endtask

  initial begin
    int w0, r0, e0;
    //        wt rdata          erd ewr rdy dn cyc sp er wr ds id
    vecs[0] = '{0, 32'h0000_0007, 0, 0, 0, 5, 11, 0, 0, 1, 1, 5'd7};
    vecs[1] = '{3, 32'h0000_0013, 0, 0, 0, 2, 14, 0, 0, 1, 1, 5'h13};
    vecs[2] = '{0, 32'hFFFF_FFE0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 5'd0};
    vecs[3] = '{0, 32'h0000_0005, 1, 0, 0, 1, 3, 0, 1, 0, 0, 5'd0};
    vecs[4] = '{0, 32'h0000_001F, 0, 1, 2, 1, 9, 0, 1, 1, 1, 5'h1F};
    vecs[5] = '{1, 32'h0000_0021, 0, 0, 1, 3, 12, 0, 0, 1, 1, 5'd1};
    vecs[6] = '{2, 32'h0000_0000, 0, 0, 0, 1, 5, 1, 0, 0, 0, 5'd0};

    presetn = 1'b0;
    en_i = 1'b0; irq_i = 1'b0;
    id_ready_i = 1'b0; done_i = 1'b0;
    cfg_wait = 0; cfg_rdata = '0;
    cfg_err_rd = 1'b0; cfg_err_wr = 1'b0;
    tick(); tick(); tick();
    chk_zero("reset");
    presetn = 1'b1;
    tick();

    // service disabled: irq must be ignored
    r0 = rd_n;
    irq_i = 1'b1;
    repeat (5) tick();
    chk("en0 busy", 32'(busy_o), 32'd0);
    chk("en0 reads", rd_n - r0, 0);
    irq_i = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // done_i before acceptance and in the acceptance cycle
    cfg_wait = 0; cfg_rdata = 32'h0B;
    w0 = wr_n;
    en_i = 1'b1; irq_i = 1'b1;
    wait_valid("h2", 1'b0);
    en_i = 1'b0;
    done_i = 1'b1; tick(); done_i = 1'b0; tick();
    chk("h2 early done ignored", 32'(id_valid_o), 32'd1);
    id_ready_i = 1'b1; done_i = 1'b1;
    tick();
    id_ready_i = 1'b0; done_i = 1'b0;
    tick(); tick(); tick();
    chk("h2 accept-cycle done busy", 32'(busy_o), 32'd1);
    chk("h2 accept-cycle done psel", 32'(bus.psel_o), 32'd0);
    done_i = 1'b1; tick(); done_i = 1'b0;
    wait_idle("h2");
    chk("h2 writes", wr_n - w0, 1);
    chk("h2 wdata", last_wdata, 32'h0B);
    repeat (4) tick();
    chk("h2 en low stays idle", 32'(busy_o), 32'd0);
    irq_i = 1'b0; en_i = 1'b1;
    tick();

    // async reset during RD_ACCESS
    cfg_wait = 3; cfg_rdata = 32'h4;
    irq_i = 1'b1;
    tick(); tick();
    chk("rst1 in access", 32'({bus.psel_o, bus.penable_o}),
        32'd3);
    presetn = 1'b0;
    #1;
    chk_zero("rst1");
    irq_i = 1'b0;
    tick();
    presetn = 1'b1;
    tick();
    run_vec(10, vecs[0]);

    // async reset during DISPATCH
    cfg_wait = 0; cfg_rdata = 32'h9;
    irq_i = 1'b1;
    wait_valid("rst2", 1'b1);
    chk("rst2 id before", 32'(id_o), 32'd9);
    presetn = 1'b0;
    #1;
    chk_zero("rst2");
    irq_i = 1'b0;
    tick();
    presetn = 1'b1;
    tick();
    run_vec(11, vecs[0]);

    // handler never signals done
    cfg_wait = 0; cfg_rdata = 32'h3;
    w0 = wr_n; e0 = err_n;
    irq_i = 1'b1;
    wait_valid("to", 1'b1);
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
`ifdef PLIC_CLAIMER_TIMEOUT_EN
    repeat (14) tick();
    chk("to cycle15 err", 32'(err_o), 32'd0);
    tick();
    chk("to cycle16 err", 32'(err_o), 32'd1);
    tick();
    chk("to wr_setup", 32'({bus.psel_o, bus.penable_o,
        bus.pwrite_o}), 32'b101);
    wait_idle("to");
    chk("to err count", err_n - e0, 1);
`else
    repeat (40) tick();
    chk("to waits busy", 32'(busy_o), 32'd1);
    chk("to no err", err_n - e0, 0);
    done_i = 1'b1; tick(); done_i = 1'b0;
    wait_idle("to");
`endif
    chk("to writes", wr_n - w0, 1);
    chk("to wdata", last_wdata, 32'h3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
